// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master arbiter for a single memory port. It picks a winner,
//            latches its request, and runs the access with programmable wait
//            states. It then returns read data and pulses the winner's ack.
// Options  : ARB_FIXED_PRIO_EN -- when defined, master 0 always wins a tie.
//            When undefined, ties are resolved round-robin.
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 13,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter reload value; WAIT_CYCLES is limited to 0..15
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic          r_owner;
    logic [3:0]    r_cnt;

    logic          w_any_req;
    logic          w_winner;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: master 1 only wins when master 0 is not asking
    always_comb begin
        w_winner = !m0_req;
    end
`else
    logic r_rr_last;

    // Round-robin: on a tie the master that did not win last time goes next
    always_comb begin
        if (m0_req && m1_req) begin
            w_winner = !r_rr_last;
        end else begin
            w_winner = m1_req;
        end
    end

    // Remember the last winner; reset to 1 so master 0 takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_rr_last <= w_winner;
        end
    end
`endif

    // Mux the winning master's request fields for latching
    always_comb begin
        w_we    = w_winner ? m1_we    : m0_we;
        w_addr  = w_winner ? m1_addr  : m0_addr;
        w_wdata = w_winner ? m1_wdata : m0_wdata;
    end

    // Transfer sequencer: IDLE arbitrates, ACCESS holds strobes, DONE acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_owner   <= 1'b0;
            r_cnt     <= 4'd0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_we      <= w_we;
                        r_owner   <= w_winner;
                        r_cnt     <= c_WAIT_LOAD;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        m0_gnt    <= !w_winner;
                        m1_gnt    <= w_winner;
                        mem_rd    <= !w_we;
                        mem_wr    <= w_we;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        if (!r_we) begin
                            rdata <= mem_rdata;
                        end
                        m0_ack  <= !r_owner;
                        m1_ack  <= r_owner;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m0_gnt  <= 1'b0;
                    m1_gnt  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter (table vectors, directed
//            corner sequences, randomized traffic against a transfer model).
//            Honours ARB_FIXED_PRIO_EN for the tie-break expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;
    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [12:0] m0_addr = 0, m1_addr = 0;
    logic [7:0]  m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, mem_rd, mem_wr;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;

    // Zero-wait-state instance, driven only through master 0
    logic        z_req = 0;
    logic [12:0] z_addr = 0;
    logic        z_m0_gnt, z_m0_ack, z_m1_gnt, z_m1_ack, z_mem_rd, z_mem_wr;
    logic [7:0]  z_rdata, z_mem_wdata, z_mem_rdata;
    logic [12:0] z_mem_addr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          mst;
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;
    vec_t vecs [5];

    // Memory macro stand-in: data is a fixed function of the address
    function automatic logic [7:0] memf(input logic [12:0] a);
        return a[7:0] ^ 8'hB5 ^ {3'b000, a[12:8]};
    endfunction

    assign mem_rdata   = memf(mem_addr);
    assign z_mem_rdata = memf(z_mem_addr);

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .AW(13), .DW(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0), .AW(13), .DW(8)) u_dut_z (
        .clk(clk), .rst_n(rst_n),
        .m0_req(z_req), .m0_we(1'b0), .m0_addr(z_addr), .m0_wdata(8'h00),
        .m0_gnt(z_m0_gnt), .m0_ack(z_m0_ack),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(13'h0000), .m1_wdata(8'h00),
        .m1_gnt(z_m1_gnt), .m1_ack(z_m1_ack),
        .rdata(z_rdata), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; bus invariants every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        chk("invariants", 32'({m0_gnt & m1_gnt, m0_ack & m1_ack, mem_rd & mem_wr}), 32'd0);
    endtask

    task automatic do_reset();
        m0_req = 0; m1_req = 0; z_req = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic set_m(input bit mst, input bit req, input bit we,
                         input logic [12:0] addr, input logic [7:0] wd);
        if (mst) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    // One isolated transfer from a table record
    task automatic run_vec(input vec_t v);
        int lat = -1, strobes = 0, other = 0, acks = 0;
        set_m(v.mst, 1'b1, v.we, v.addr, v.wdata);
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (mem_rd || mem_wr) begin
                strobes++;
                chk("vec_addr", 32'(mem_addr), 32'(v.addr));
                chk("vec_dir", 32'(mem_wr), 32'(v.we));
                if (v.we) chk("vec_wdata", 32'(mem_wdata), 32'(v.wdata));
            end
            if (v.mst ? m0_gnt : m1_gnt) other++;
            if (v.mst ? m1_ack : m0_ack) begin
                acks++;
                if (lat < 0) lat = t;
                set_m(v.mst, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        chk("vec_latency", 32'(lat), 32'(W + 2));
        chk("vec_strobes", 32'(strobes), 32'(W + 1));
        chk("vec_acks", 32'(acks), 32'd1);
        chk("vec_other_gnt", 32'(other), 32'd0);
        chk("vec_rdata", 32'(rdata), 32'(v.exp_rdata));
    endtask

    // Random driver for one master; obeys hold-until-ack
    task automatic rand_drive(input bit mst);
        logic req, gnt, ack;
        req = mst ? m1_req : m0_req;
        gnt = mst ? m1_gnt : m0_gnt;
        ack = mst ? m1_ack : m0_ack;
        if (!req) begin
            if ($urandom_range(0, 2) == 0)
                set_m(mst, 1'b1, 1'($urandom), 13'($urandom), 8'($urandom));
        end else if (ack) begin
            if ($urandom_range(0, 1) == 0) set_m(mst, 1'b0, 1'b0, 13'h0, 8'h0);
            else set_m(mst, 1'b1, 1'($urandom), 13'($urandom), 8'($urandom));
        end else if (gnt) begin
            if ($urandom_range(0, 2) == 0)
                set_m(mst, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                      13'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, ack0, ack1, lat, strobes, acks;
        int order [8];
        logic p0, p1;
        // Transfer-level model state
        bit          busy, mo, mwe, rr, win;
        int          ph;
        logic [12:0] maddr;
        logic [7:0]  mwd, mrd;

        vecs[0] = '{1'b0, 1'b0, 13'h0010, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h55};
        vecs[3] = '{1'b0, 1'b1, 13'h0000, 8'hFF, 8'h55};
        vecs[4] = '{1'b0, 1'b0, 13'h0100, 8'h00, 8'hB4};

        // Reset values
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({m0_gnt, m1_gnt, m0_ack, m1_ack, mem_rd, mem_wr}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Both masters requesting continuously
        do_reset();
        set_m(0, 1'b1, 1'b0, 13'h00AA, 8'h00);
        set_m(1, 1'b1, 1'b0, 13'h0155, 8'h00);
        ng = 0; ack0 = 0; ack1 = 0; p0 = 0; p1 = 0;
        for (int i = 0; i < 8; i++) order[i] = 3;
        for (int t = 0; t < 4 * (W + 3); t++) begin
            tick();
            if (m0_gnt && !p0 && ng < 8) begin order[ng] = 0; ng++; end
            if (m1_gnt && !p1 && ng < 8) begin order[ng] = 1; ng++; end
            if (m0_ack) ack0++;
            if (m1_ack) ack1++;
            p0 = m0_gnt; p1 = m1_gnt;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("tie_order", 32'(order[i]), 32'd0);
`else
            chk("tie_order", 32'(order[i]), 32'(i % 2));
`endif
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("tie_ack0", 32'(ack0), 32'd4);
        chk("tie_ack1", 32'(ack1), 32'd0);
`else
        chk("tie_ack0", 32'(ack0), 32'd2);
        chk("tie_ack1", 32'(ack1), 32'd2);
`endif
        m0_req = 0; m1_req = 0;
        repeat (W + 3) tick();

        // Request dropped and address changed while granted
        set_m(0, 1'b1, 1'b0, 13'h0040, 8'h00);
        tick();
        chk("drop_gnt", 32'(m0_gnt), 32'd1);
        set_m(0, 1'b0, 1'b1, 13'h0005, 8'h99);
        acks = 0;
        for (int t = 0; t < 10; t++) begin
            if (mem_rd || mem_wr) begin
                chk("drop_addr", 32'(mem_addr), 32'h0040);
                chk("drop_rd", 32'(mem_rd), 32'd1);
            end
            if (m0_ack) acks++;
            tick();
        end
        chk("drop_acks", 32'(acks), 32'd1);
        chk("drop_rdata", 32'(rdata), 32'hF5);

        // Reset in the middle of a master 1 write
        set_m(1, 1'b1, 1'b1, 13'h0123, 8'h77);
        tick();
        chk("rstmid_pre", 32'({m1_gnt, mem_wr}), 32'b11);
        #2 rst_n = 0;
        #1;
        chk("rstmid_async", 32'({m1_gnt, mem_wr, m1_ack}), 32'd0);
        m1_req = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        acks = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (m1_ack || m1_gnt) acks++;
        end
        chk("rstmid_no_ack", 32'(acks), 32'd0);
        set_m(0, 1'b1, 1'b0, 13'h0010, 8'h00);
        set_m(1, 1'b1, 1'b0, 13'h0020, 8'h00);
        tick();
        chk("rstmid_first_tie", 32'({m0_gnt, m1_gnt}), 32'b10);
        m0_req = 0; m1_req = 0;
        repeat (W + 3) tick();

        // Zero wait states: one ACCESS cycle, ack two edges after sampling
        z_req = 1; z_addr = 13'h0010;
        lat = -1; strobes = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (z_mem_rd) strobes++;
            if (z_m0_ack) begin
                if (lat < 0) lat = t;
                z_req = 0;
            end
        end
        chk("w0_strobes", 32'(strobes), 32'd1);
        chk("w0_latency", 32'(lat), 32'd2);
        chk("w0_rdata", 32'(z_rdata), 32'hA5);

        // Randomized traffic against the transfer model
        do_reset();
        busy = 0; mo = 0; mwe = 0; rr = 1; ph = 0;
        maddr = 0; mwd = 0; mrd = 0; win = 0;
        for (int c = 0; c < 800; c++) begin
            tick();
            if (busy) begin
                ph++;
                if (ph == W + 1 && !mwe) mrd = memf(maddr);
                if (ph == W + 2) busy = 0;
            end else if (m0_req || m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                win = !m0_req;
`else
                win = (m0_req && m1_req) ? !rr : m1_req;
                rr = win;
`endif
                busy = 1; ph = 0; mo = win;
                mwe   = win ? m1_we    : m0_we;
                maddr = win ? m1_addr  : m0_addr;
                mwd   = win ? m1_wdata : m0_wdata;
            end
            chk("rnd_gnt", 32'({m0_gnt, m1_gnt}), 32'({busy && !mo, busy && mo}));
            chk("rnd_ack", 32'({m0_ack, m1_ack}),
                32'({busy && ph == W + 1 && !mo, busy && ph == W + 1 && mo}));
            chk("rnd_strobe", 32'({mem_rd, mem_wr}),
                32'({busy && ph <= W && !mwe, busy && ph <= W && mwe}));
            if (busy && ph <= W) chk("rnd_addr", 32'(mem_addr), 32'(maddr));
            if (busy && ph <= W && mwe) chk("rnd_wdata", 32'(mem_wdata), 32'(mwd));
            chk("rnd_rdata", 32'(rdata), 32'(mrd));
            rand_drive(1'b0);
            rand_drive(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
